// File: rtl/env_memctl_pkg.sv
// Shared types and default sizing for the tv80 memory-region controller.
package env_memctl_pkg;

  localparam int unsigned DEF_NUM_REGIONS = 4;
  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DEF_WAIT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/env_region_match.sv
// One decode region: enabled base/mask compare against the CPU address.
import env_memctl_pkg::*;

module env_region_match #(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  input  logic              en,
  output logic              hit
);

  assign hit = en & ((addr & mask) == (base & mask));

endmodule

// File: rtl/env_memctl.sv
// Region decoder, chip-select generation and wait-state inserter between
// the tv80 memory strobes and the async memories.
import env_memctl_pkg::*;

module env_memctl #(
  parameter int unsigned NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned WAIT_W      = DEF_WAIT_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mreq_n,
  input  logic                          rd_n,
  input  logic                          wr_n,
  input  logic                          rfsh_n,
  input  logic [ADDR_W-1:0]             A,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask,
  input  logic [NUM_REGIONS-1:0]        region_en,
  input  logic [NUM_REGIONS-1:0]        region_wp,
  input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
  output logic [NUM_REGIONS-1:0]        rd_cs,
  output logic [NUM_REGIONS-1:0]        wr_cs,
  output logic                          wait_n,
  output logic                          unmapped,
  output logic                          wp_err,
  input  logic                          wp_err_clr
);

  localparam int unsigned IDX_W = idx_width(NUM_REGIONS);

  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] sel;
  logic [IDX_W-1:0]       sel_idx;
  logic                   any_hit;
  logic                   acc;
  logic [WAIT_W-1:0]      wait_sel;
  logic                   wp_hit;

  state_e            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic              wait_n_q;
  logic              unmapped_q;
  logic              wp_err_q;

  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
    env_region_match #(.ADDR_W(ADDR_W)) u_match (
      .addr (A),
      .base (region_base[r*ADDR_W +: ADDR_W]),
      .mask (region_mask[r*ADDR_W +: ADDR_W]),
      .en   (region_en[r]),
      .hit  (hit[r])
    );
  end

  assign acc = ~mreq_n & rfsh_n & (~rd_n | ~wr_n);

  // Lowest index wins on overlapping regions.
  always_comb begin
    sel_idx = '0;
    any_hit = 1'b0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (hit[r]) begin
        sel_idx = IDX_W'(r);
        any_hit = 1'b1;
      end
    end
    sel = any_hit ? (NUM_REGIONS'(1) << sel_idx) : '0;
  end

  assign wait_sel = region_wait[32'(sel_idx)*WAIT_W +: WAIT_W];
  assign wp_hit   = acc & ~wr_n & any_hit & region_wp[sel_idx];

  // Live decode; forced off while reset is asserted.
  assign rd_cs = (acc & reset_n & ~rd_n) ? sel : '0;
  assign wr_cs = (acc & reset_n & ~wr_n) ? (sel & ~region_wp) : '0;

  assign wait_n   = wait_n_q;
  assign unmapped = unmapped_q;
  assign wp_err   = wp_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wait_n_q   <= 1'b1;
      unmapped_q <= 1'b0;
      wp_err_q   <= 1'b0;
    end else begin
      unmapped_q <= 1'b0;
      if (wp_err_clr) wp_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            if (!any_hit) begin
              unmapped_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              // Set takes priority over a simultaneous clear.
              if (wp_hit) wp_err_q <= 1'b1;
              cnt_q <= wait_sel;
              if (wait_sel != '0) begin
                wait_n_q <= 1'b0;
                state_q  <= ST_WAIT;
              end else begin
                state_q  <= ST_DONE;
              end
            end
          end
        end
        ST_WAIT: begin
          if (mreq_n) begin
            wait_n_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
          end else if (cnt_q == WAIT_W'(1)) begin
            wait_n_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        ST_DONE: begin
          if (mreq_n) state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          wait_n_q <= 1'b1;
          cnt_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_env_memctl.sv
// Directed bench for env_memctl with a small behavioural RAM behind wr_cs.
module tb_env_memctl;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned WW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            mreq_n, rd_n, wr_n, rfsh_n;
  logic [AW-1:0]   A;
  logic [NR*AW-1:0] region_base, region_mask;
  logic [NR-1:0]   region_en, region_wp;
  logic [NR*WW-1:0] region_wait;
  logic [NR-1:0]   rd_cs, wr_cs;
  logic            wait_n, unmapped, wp_err, wp_err_clr;

  logic [7:0] wdata;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  env_memctl #(.NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW)) dut (
    .clk(clk), .reset_n(reset_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .rfsh_n(rfsh_n), .A(A), .region_base(region_base), .region_mask(region_mask),
    .region_en(region_en), .region_wp(region_wp), .region_wait(region_wait),
    .rd_cs(rd_cs), .wr_cs(wr_cs), .wait_n(wait_n), .unmapped(unmapped),
    .wp_err(wp_err), .wp_err_clr(wp_err_clr)
  );

  always #5 clk = ~clk;

  // RAM completes the write on an edge where the CPU is not being held.
  always @(posedge clk) begin
    if (|wr_cs && wait_n) mem[A[7:0]] <= wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_region(input int r, input logic [15:0] base, input logic [15:0] mask,
                            input logic en, input logic wp, input logic [3:0] wt);
    region_base[r*AW +: AW] = base;
    region_mask[r*AW +: AW] = mask;
    region_en[r]            = en;
    region_wp[r]            = wp;
    region_wait[r*WW +: WW] = wt;
  endtask

  // One full CPU memory cycle held for 12 clocks, then released.
  task automatic bus_cycle(input logic [15:0] addr, input logic wr, input logic [7:0] dat,
                           input logic clr0, output int waits, output int first_low,
                           output int unm, output logic [3:0] rcs, output logic [3:0] wcs);
    @(negedge clk);
    A = addr; wdata = dat; mreq_n = 1'b0; rd_n = wr; wr_n = ~wr; wp_err_clr = clr0;
    #1;
    rcs = rd_cs; wcs = wr_cs;
    waits = 0; first_low = -1; unm = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wp_err_clr = 1'b0;
      if (!wait_n) begin
        waits++;
        if (first_low < 0) first_low = i;
      end
      if (unmapped) unm++;
    end
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
  endtask

  int waits, first_low, unm, viol;
  logic [3:0] rcs, wcs;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset_n = 1'b0; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    A = '0; wdata = '0; wp_err_clr = 1'b0;
    region_base = '0; region_mask = '0; region_en = '0; region_wp = '0; region_wait = '0;

    // 1: reset held 20 clocks, outputs quiet throughout
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wait_n !== 1'b1 || rd_cs !== 4'b0 || wr_cs !== 4'b0 || wp_err !== 1'b0 || unmapped !== 1'b0)
        viol++;
    end
    chk("reset_quiet", 32'(viol), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wait_n", 32'(wait_n), 1);
    chk("post_rst_unmapped", 32'(unmapped), 0);
    chk("post_rst_wp_err", 32'(wp_err), 0);

    // 2: zero-wait read of the low half
    set_region(0, 16'h0000, 16'h8000, 1'b1, 1'b0, 4'd0);
    set_region(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 4'd3);
    bus_cycle(16'h1234, 1'b0, 8'h00, 1'b0, waits, first_low, unm, rcs, wcs);
    chk("rd0_rcs", 32'(rcs), 32'h1);
    chk("rd0_waits", 32'(waits), 0);

    // 3: three-wait write to region 1
    bus_cycle(16'h9000, 1'b1, 8'hA5, 1'b0, waits, first_low, unm, rcs, wcs);
    chk("wr1_wcs", 32'(wcs), 32'h2);
    chk("wr1_waits", 32'(waits), 3);
    chk("wr1_first_low", 32'(first_low), 0);
    chk("wr1_ram", 32'(mem[8'h00]), 32'hA5);

    // 4: overlap of regions 0 and 2, region 0 wins with its own count
    set_region(0, 16'h8000, 16'h8000, 1'b1, 1'b0, 4'd2);
    set_region(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);
    set_region(2, 16'h8100, 16'hFF00, 1'b1, 1'b0, 4'd5);
    bus_cycle(16'h8100, 1'b0, 8'h00, 1'b0, waits, first_low, unm, rcs, wcs);
    chk("ovl_rcs", 32'(rcs), 32'h1);
    chk("ovl_waits", 32'(waits), 2);

    // 5: protected write; clear asserted on the start edge must lose
    set_region(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);
    set_region(2, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);
    set_region(1, 16'h8000, 16'h8000, 1'b1, 1'b1, 4'd1);
    bus_cycle(16'h8004, 1'b1, 8'h3C, 1'b1, waits, first_low, unm, rcs, wcs);
    chk("wp_wcs", 32'(wcs), 0);
    chk("wp_ram", 32'(mem[8'h04]), 0);
    chk("wp_waits", 32'(waits), 1);
    chk("wp_err_set", 32'(wp_err), 1);
    repeat (3) @(negedge clk);
    chk("wp_err_sticky", 32'(wp_err), 1);
    wp_err_clr = 1'b1;
    @(negedge clk);
    wp_err_clr = 1'b0;
    chk("wp_err_cleared", 32'(wp_err), 0);

    // 6: nothing enabled -> single unmapped pulse
    region_en = '0;
    bus_cycle(16'h4000, 1'b0, 8'h00, 1'b0, waits, first_low, unm, rcs, wcs);
    chk("unm_pulses", 32'(unm), 1);
    chk("unm_rcs", 32'(rcs), 0);
    chk("unm_waits", 32'(waits), 0);

    // refresh cycle on a live region: ignored entirely
    set_region(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 4'd7);
    rfsh_n = 1'b0;
    bus_cycle(16'h8010, 1'b0, 8'h00, 1'b0, waits, first_low, unm, rcs, wcs);
    rfsh_n = 1'b1;
    chk("rfsh_rcs", 32'(rcs), 0);
    chk("rfsh_waits", 32'(waits), 0);
    chk("rfsh_unm", 32'(unm), 0);

    // abort: mreq_n released while waiting
    @(negedge clk);
    A = 16'h8020; mreq_n = 1'b0; rd_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_pre_wait_n", 32'(wait_n), 0);
    mreq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    chk("abort_wait_n", 32'(wait_n), 1);
    set_region(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 4'd2);
    bus_cycle(16'h8030, 1'b0, 8'h00, 1'b0, waits, first_low, unm, rcs, wcs);
    chk("post_abort_rcs", 32'(rcs), 32'h2);
    chk("post_abort_waits", 32'(waits), 2);

    // async reset during a 7-wait access
    set_region(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 4'd7);
    @(negedge clk);
    A = 16'h8040; mreq_n = 1'b0; rd_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_pre", 32'(wait_n), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_wait_n", 32'(wait_n), 1);
    chk("rst_mid_rcs", 32'(rd_cs), 0);
    @(negedge clk);
    mreq_n = 1'b1; rd_n = 1'b1; reset_n = 1'b1;
    bus_cycle(16'h8050, 1'b0, 8'h00, 1'b0, waits, first_low, unm, rcs, wcs);
    chk("post_rst_access_waits", 32'(waits), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
